pri_irq_encoder: RTL and testbench
==================================

Name: pri_irq_encoder

Overview:
- Parametrised, registered successor to the 8:3 priority encoder.
- Captures rising edges on N request lines into a pending register and applies a per-line mask.
- Presents the highest-priority pending index with a valid/ack handshake, then clears the serviced bit.
- Sits between peripheral event lines and a simple controller that services one event at a time.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, $clog2(N), index width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low = capture frozen, output idle.
- req  in  N  level request lines, synchronous to clk.
- mask  in  N  1 = line blocked from selection; pending bit is kept.
- ack  in  1  consumer accepts the presented index.
- y  out  W  encoded index of the selected request.
- valid  out  1  y is meaningful.
- pending  out  N  current pending register.

Behaviour:
- Reset (rst_n low, asynchronous): req_q=0, pending=0, y=0, valid=0, state=IDLE. Reset mid-handshake discards everything.
- Edge capture:
  - req_q <= req every cycle.
  - When en=1, pending[i] is set on the edge where req[i]=1 and req_q[i]=0.
  - Level-high lines never re-trigger.
  - When en=0, edges are ignored and req_q still tracks req.
- Selection: fixed priority, highest index wins, among pending & ~mask.
- FSM:
  - IDLE:
    - If en and (pending & ~mask) != 0, register y = selected index, valid <= 1, go to PRESENT.
    - Otherwise valid stays 0.
  - PRESENT: y is held stable while valid is high, even if a higher-priority request arrives.
    - On ack=1: clear pending[y], valid <= 0, go to CLEAR.
    - On mask[y] rising while waiting: keep presenting; masking does not revoke.
  - CLEAR: one dead cycle so the cleared bit is not reselected; then go to IDLE.
- Latency: req rising sampled at edge k -> pending set at edge k -> valid high after edge k+1.
- Throughput: one grant per 3 cycles, with back-to-back ack.
- Simultaneous events:
  - A new rising edge on bit y in the same cycle as the ack that clears it: set wins, and the bit stays pending.
  - ack while valid=0 is ignored.
- en dropping to 0:
  - In PRESENT: valid <= 0, go to IDLE, pending retained, nothing cleared.
  - In CLEAR: completes normally.
- All-masked or empty pending: remains in IDLE, valid=0, y holds its last value.
- Width rule: y is zero-extended index within W bits; N that is not a power of two is legal, and unused codes never appear.

Optional Feature:
- Macro: PRI_IRQ_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. A last-grant register (W bits, reset to N-1) makes the search start at last+1, wrapping, then descend.
  - Concretely, the chosen index is the first candidate scanning last+1, last+2, ... modulo N, then wrapping.
  - Last-grant updates on ack.
- Undefined: fixed highest-index priority as above; no last-grant register.

Decomposition:
- Shared package pri_enc_pkg:
  - state enum {IDLE, PRESENT, CLEAR}.
  - clog2 helper function.
  - localparam for reset state encoding.
- Sub-module priority_pick (parameter N):
  - Combinational find-highest-set over an N-bit vector.
  - Outputs: index W and any-set flag.
  - Round-robin mode rotates its input by last+1 before the call and rotates the result back.

Test Plan:
- Reset: rst_n low mid-PRESENT with pending=8'h84 -> valid, pending and y go to 0 immediately, not waiting for clk.
- Single request: en=1, req=8'h01 rising -> pending=8'h01; valid=1, y=0 one cycle later; ack -> pending=0, valid=0, CLEAR, then IDLE.
- Priority: req=8'h29 rising together -> y=5 first; after ack, y=3; after ack, y=0; pending sequence 29->09->01->00.
- Mask and level: mask=8'h80, req=8'h81 rising -> y=0. Holding req[0] high after ack gives no new grant. Clearing mask -> y=7.
- Set/clear collision: present y=2, drop then re-raise req[2] so its rising edge coincides with ack -> pending[2] remains 1; y=2 is presented again after CLEAR.
- Round robin (macro defined): all 8 lines pending, continuous ack -> grant order 0,1,2,...,7 starting from reset last=7; no starvation of index 0.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the registered priority interrupt encoder.
package pri_enc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      CLEAR   = 2'd2
   } state_e;

   localparam state_e STATE_RST = IDLE;

   // Ceiling log2, floored at 1 so a 2-line encoder still gets a 1-bit index.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pri_irq_encoder_priority_pick.sv
// Combinational find-highest-set over an N-bit vector; zero latency, no flow control.
module priority_pick
   import pri_enc_pkg::*;
#(
   parameter int  N = 8,
   localparam int W = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pri_irq_encoder.sv
// Edge-captured, maskable priority encoder with valid/ack handshake; one grant per 3 cycles.
// Define PRI_IRQ_ROUND_ROBIN_EN for rotating priority starting after the last acked index.
module pri_irq_encoder
   import pri_enc_pkg::*;
#(
   parameter int  N = 8,
   localparam int W = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         ack,
   output logic [W-1:0] y,
   output logic         valid,
   output logic [N-1:0] pending
);

   state_e       state_q, state_d;
   logic [N-1:0] req_q;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] y_q, y_d;
   logic         valid_q, valid_d;
   logic [N-1:0] cand;
   logic [N-1:0] clr;
   logic [W-1:0] sel_idx;
   logic         pick_any;
   logic         accept;

   assign cand = pend_q & ~mask;

`ifdef PRI_IRQ_ROUND_ROBIN_EN
   logic [W-1:0] last_q, last_d;
   logic [N-1:0] rot_vec;
   logic [W-1:0] rot_idx;

   // Candidate at offset j after last lands at bit N-1-j, so highest-set means first after last.
   always_comb begin
      rot_vec = '0;
      for (int j = 0; j < N; j++) begin
         rot_vec[N-1-j] = cand[(int'(last_q) + 1 + j) % N];
      end
   end

   priority_pick #(.N(N)) u_pick (
      .vec (rot_vec),
      .idx (rot_idx),
      .any (pick_any)
   );

   assign sel_idx = W'((int'(last_q) + N - int'(rot_idx)) % N);
   assign last_d  = accept ? y_q : last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= W'(N - 1);
      else        last_q <= last_d;
   end
`else
   priority_pick #(.N(N)) u_pick (
      .vec (cand),
      .idx (sel_idx),
      .any (pick_any)
   );
`endif

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      valid_d = valid_q;
      clr     = '0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && pick_any) begin
               y_d     = sel_idx;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // Losing enable abandons the offer without consuming the pending bit.
            if (!en) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (ack) begin
               accept  = 1'b1;
               clr     = {{(N-1){1'b0}}, 1'b1} << y_q;
               valid_d = 1'b0;
               state_d = CLEAR;
            end
         end
         CLEAR: state_d = IDLE;
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      // A fresh rising edge overrides the clear of the same bit.
      pend_d = (pend_q & ~clr) | (en ? (req & ~req_q) : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STATE_RST;
         req_q   <= '0;
         pend_q  <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req;
         pend_q  <= pend_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign y       = y_q;
   assign valid   = valid_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_pri_irq_encoder.sv
// Directed bench for pri_irq_encoder with a queue of expected grant indices.
module tb_pri_irq_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         ack;
   logic [W-1:0] y;
   logic         valid;
   logic [N-1:0] pending;

   int checks   = 0;
   int failures = 0;
   int expq[$];

   pri_irq_encoder #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .mask    (mask),
      .ack     (ack),
      .y       (y),
      .valid   (valid),
      .pending (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_present(input string tag, output int waited);
      int e;
      waited = 0;
      while (valid !== 1'b1 && waited < 10) begin
         tick();
         waited++;
      end
      check({tag, "_valid"}, 32'(valid), 32'd1);
      e = (expq.size() > 0) ? expq.pop_front() : -1;
      check({tag, "_y"}, 32'(y), e);
   endtask

   task automatic do_ack(input string tag, input logic [N-1:0] exp_pend);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_ack_valid"}, 32'(valid), 32'd0);
      check({tag, "_ack_pend"}, 32'(pending), 32'(exp_pend));
      tick();
   endtask

   initial begin
      int n;
      int rexp;
      logic [N-1:0] ep;

      rst_n = 1'b0;
      en    = 1'b0;
      req   = '0;
      mask  = '0;
      ack   = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request: pending on the capture edge, valid one edge later.
      en  = 1'b1;
      req = 8'h01;
      expq.push_back(0);
      tick();
      check("single_pend", 32'(pending), 32'h01);
      check("single_early_valid", 32'(valid), 32'd0);
      tick();
      check("single_lat_valid", 32'(valid), 32'd1);
      expect_present("single", n);
      do_ack("single", 8'h00);
      check("single_idle_valid", 32'(valid), 32'd0);
      req = '0;
      tick();

      // Asynchronous reset while a grant is presented.
`ifdef PRI_IRQ_ROUND_ROBIN_EN
      rexp = 2;
`else
      rexp = 7;
`endif
      req = 8'h84;
      expq.push_back(rexp);
      tick();
      check("arst_pend_pre", 32'(pending), 32'h84);
      expect_present("arst", n);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_pend", 32'(pending), 32'd0);
      check("arst_y", 32'(y), 32'd0);
      tick();
      req   = '0;
      rst_n = 1'b1;
      tick();

`ifdef PRI_IRQ_ROUND_ROBIN_EN
      req = 8'hFF;
      tick();
      check("rr_pend", 32'(pending), 32'hFF);
      for (int i = 0; i < N; i++) begin
         expq.push_back(i);
         expect_present("rr", n);
         ep = 8'hFF << (i + 1);
         do_ack("rr", ep);
      end
      req = '0;
      tick();
`else
      // Fixed priority with back-to-back grants every three cycles.
      req = 8'h29;
      expq.push_back(5);
      expq.push_back(3);
      expq.push_back(0);
      tick();
      check("prio_pend", 32'(pending), 32'h29);
      expect_present("prio5", n);
      do_ack("prio5", 8'h09);
      expect_present("prio3", n);
      check("prio3_gap", 32'(n), 32'd1);
      do_ack("prio3", 8'h01);
      expect_present("prio0", n);
      check("prio0_gap", 32'(n), 32'd1);
      do_ack("prio0", 8'h00);
      req = '0;
      tick();

      // Mask blocks bit 7; level-high bit 0 must not retrigger; stray ack ignored.
      mask = 8'h80;
      req  = 8'h81;
      expq.push_back(0);
      tick();
      expect_present("mask0", n);
      do_ack("mask0", 8'h80);
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      check("mask_idle_valid", 32'(valid), 32'd0);
      check("mask_idle_pend", 32'(pending), 32'h80);
      check("mask_idle_y", 32'(y), 32'd0);
      mask = 8'h00;
      expq.push_back(7);
      expect_present("mask7", n);
      mask = 8'h80;
      tick();
      check("mask_hold_valid", 32'(valid), 32'd1);
      check("mask_hold_y", 32'(y), 32'd7);
      do_ack("mask7", 8'h00);
      mask = '0;
      req  = '0;
      tick();

      // Re-raise on the same edge as ack: the set survives the clear.
      req = 8'h04;
      expq.push_back(2);
      tick();
      req = 8'h00;
      expect_present("coll_a", n);
      req = 8'h04;
      expq.push_back(2);
      do_ack("coll_a", 8'h04);
      expect_present("coll_b", n);
      do_ack("coll_b", 8'h00);
      req = '0;
      tick();

      // Enable drop withdraws the offer and freezes capture.
      req = 8'h02;
      expq.push_back(1);
      tick();
      expect_present("en_a", n);
      en  = 1'b0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("en_drop_valid", 32'(valid), 32'd0);
      check("en_drop_pend", 32'(pending), 32'h02);
      req = 8'h42;
      tick();
      tick();
      check("en_frozen_pend", 32'(pending), 32'h02);
      check("en_frozen_valid", 32'(valid), 32'd0);
      en = 1'b1;
      expq.push_back(1);
      expect_present("en_b", n);
      do_ack("en_b", 8'h00);
      req = '0;
      tick();
`endif

      check("sb_drained", 32'(expq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
